// File: rtl/snake_body_engine.sv
// snake_body_engine: owns the snake coordinate store. Each move_tick shifts
// the body back one slot, one entry per cycle, then moves the head one unit in
// the latched direction. It also handles growth requests and respawn commands,
// and exposes the store through a combinational read port.
module snake_body_engine #(
    parameter int COORD_WIDTH  = 10,
    parameter int MAX_LENGTH   = 63,
    parameter int LENGTH_WIDTH = 6,
    parameter int START_X      = 32,
    parameter int START_Y      = 24,
    parameter int START_LEN    = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    move_tick,
    input  logic [1:0]              dir_in,
    input  logic                    grow,
    input  logic                    respawn_valid,
    input  logic [COORD_WIDTH-1:0]  respawn_x,
    input  logic [COORD_WIDTH-1:0]  respawn_y,
    input  logic [LENGTH_WIDTH-1:0] respawn_length,
    input  logic [LENGTH_WIDTH-1:0] body_rd_addr,
    output logic [COORD_WIDTH-1:0]  body_rd_x,
    output logic [COORD_WIDTH-1:0]  body_rd_y,
    output logic [COORD_WIDTH-1:0]  head_x,
    output logic [COORD_WIDTH-1:0]  head_y,
    output logic [LENGTH_WIDTH-1:0] snake_length,
    output logic                    busy,
    output logic                    step_done,
    output logic                    overrun
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_HEAD
    } state_t;

    localparam logic [LENGTH_WIDTH-1:0] LP_MAX = LENGTH_WIDTH'(MAX_LENGTH);
    localparam logic [LENGTH_WIDTH-1:0] LP_ONE = LENGTH_WIDTH'(1);
    localparam logic [COORD_WIDTH-1:0]  LP_C1  = COORD_WIDTH'(1);
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [COORD_WIDTH-1:0]  r_x [0:MAX_LENGTH];
    logic [COORD_WIDTH-1:0]  r_y [0:MAX_LENGTH];
    logic [LENGTH_WIDTH-1:0] r_len;
    logic [LENGTH_WIDTH-1:0] r_idx;
    logic [1:0]              r_dir;
    logic                    r_grow_pend;
    logic                    r_grow_step;
    logic                    r_step_done;
    logic                    r_overrun;

    logic                    w_growing;
    logic                    w_can_grow;
    logic [LENGTH_WIDTH-1:0] w_shift_n;
    logic                    w_reversal;
    logic [LENGTH_WIDTH-1:0] w_resp_len;
    logic [COORD_WIDTH-1:0]  w_new_hx;
    logic [COORD_WIDTH-1:0]  w_new_hy;

    // A grow arriving in the same cycle as the tick counts for that step.
    assign w_growing  = r_grow_pend | grow;
    assign w_can_grow = w_growing && (r_len < LP_MAX);
    // Growing keeps the old tail by shifting one extra entry.
    assign w_shift_n  = w_can_grow ? r_len : (r_len - LP_ONE);
    // Bit 1 flips between opposite directions (up/down, right/left).
    assign w_reversal = (r_len > LP_ONE) && (dir_in == (r_dir ^ 2'b10));
    assign w_resp_len = (respawn_length == '0)   ? LP_ONE :
                        (respawn_length > LP_MAX) ? LP_MAX : respawn_length;

    assign body_rd_x    = r_x[body_rd_addr];
    assign body_rd_y    = r_y[body_rd_addr];
    assign head_x       = r_x[0];
    assign head_y       = r_y[0];
    assign snake_length = r_len;
    assign busy         = (r_state != ST_IDLE);
    assign step_done    = r_step_done;
    assign overrun      = r_overrun;

    // Next head position: one unit in the latched direction, modulo 2^COORD_WIDTH.
    always_comb begin
        w_new_hx = r_x[0];
        w_new_hy = r_y[0];
        case (r_dir)
            DIR_UP:    w_new_hy = r_y[0] - LP_C1;
            DIR_RIGHT: w_new_hx = r_x[0] + LP_C1;
            DIR_DOWN:  w_new_hy = r_y[0] + LP_C1;
            DIR_LEFT:  w_new_hx = r_x[0] - LP_C1;
            default:   ;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; respawn aborts any step in progress.
    always_comb begin
        w_state_next = r_state;
        if (respawn_valid) begin
            w_state_next = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (move_tick) begin
                        w_state_next = (w_shift_n == '0) ? ST_HEAD : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (r_idx == LP_ONE) begin
                        w_state_next = ST_HEAD;
                    end
                end
                ST_HEAD: w_state_next = ST_IDLE;
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // Coordinate store, length, direction and step bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i <= MAX_LENGTH; i++) begin
                if (i < START_LEN) begin
                    r_x[i] <= COORD_WIDTH'(START_X - i);
                    r_y[i] <= COORD_WIDTH'(START_Y);
                end else begin
                    r_x[i] <= '0;
                    r_y[i] <= '0;
                end
            end
            r_len       <= LENGTH_WIDTH'(START_LEN);
            r_idx       <= '0;
            r_dir       <= DIR_RIGHT;
            r_grow_pend <= 1'b0;
            r_grow_step <= 1'b0;
            r_step_done <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (respawn_valid) begin
            // A simultaneous tick is dropped silently; direction is kept.
            r_x[0]      <= respawn_x;
            r_y[0]      <= respawn_y;
            r_len       <= w_resp_len;
            r_grow_pend <= 1'b0;
            r_step_done <= 1'b0;
        end else begin
            r_step_done <= 1'b0;
            r_grow_pend <= r_grow_pend | grow;
            if (move_tick && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (move_tick) begin
                        if (!w_reversal) begin
                            r_dir <= dir_in;
                        end
                        r_grow_step <= w_growing;
                        r_idx       <= w_shift_n;
                    end
                end
                ST_SHIFT: begin
                    r_x[r_idx] <= r_x[r_idx - LP_ONE];
                    r_y[r_idx] <= r_y[r_idx - LP_ONE];
                    r_idx      <= r_idx - LP_ONE;
                end
                ST_HEAD: begin
                    r_x[0] <= w_new_hx;
                    r_y[0] <= w_new_hy;
                    if (r_grow_step && (r_len < LP_MAX)) begin
                        r_len <= r_len + LP_ONE;
                    end
                    r_step_done <= 1'b1;
                    // The consumed request is cleared (even if saturated);
                    // a grow sampled in this same cycle is kept for later.
                    r_grow_pend <= grow | (r_grow_pend & ~r_grow_step);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_snake_body_engine.sv
// Bench for snake_body_engine: directed stimulus, a list-based model of the
// snake checked every cycle, plus hand-computed literal expectations.
module tb_snake_body_engine;

    localparam int CW = 10;
    localparam int ML = 63;
    localparam int LW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          move_tick;
    logic [1:0]    dir_in;
    logic          grow;
    logic          respawn_valid;
    logic [CW-1:0] respawn_x;
    logic [CW-1:0] respawn_y;
    logic [LW-1:0] respawn_length;
    logic [LW-1:0] body_rd_addr;
    logic [CW-1:0] body_rd_x;
    logic [CW-1:0] body_rd_y;
    logic [CW-1:0] head_x;
    logic [CW-1:0] head_y;
    logic [LW-1:0] snake_length;
    logic          busy;
    logic          step_done;
    logic          overrun;

    snake_body_engine dut (
        .clk            (clk),
        .reset          (reset),
        .move_tick      (move_tick),
        .dir_in         (dir_in),
        .grow           (grow),
        .respawn_valid  (respawn_valid),
        .respawn_x      (respawn_x),
        .respawn_y      (respawn_y),
        .respawn_length (respawn_length),
        .body_rd_addr   (body_rd_addr),
        .body_rd_x      (body_rd_x),
        .body_rd_y      (body_rd_y),
        .head_x         (head_x),
        .head_y         (head_y),
        .snake_length   (snake_length),
        .busy           (busy),
        .step_done      (step_done),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit addr_hold = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    // The snake is a list of cells, head first. An accepted tick computes the
    // whole next list at once; it becomes visible once the step's latency
    // (equal to the new length) has elapsed.
    logic [CW-1:0] m_x [0:ML];
    logic [CW-1:0] m_y [0:ML];
    logic [CW-1:0] p_x [0:ML];
    logic [CW-1:0] p_y [0:ML];
    int            m_len;
    int            p_len;
    int            m_cnt;
    logic [1:0]    m_dir;
    bit            m_gp;
    bit            m_step_grow;
    bit            m_done;
    bit            m_ovr;
    bit            m_valid = 1'b0;
    bit            m_g;

    function automatic bit is_reversal(input logic [1:0] a, input logic [1:0] b);
        return (a == 2'd0 && b == 2'd2) || (a == 2'd2 && b == 2'd0) ||
               (a == 2'd1 && b == 2'd3) || (a == 2'd3 && b == 2'd1);
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i <= ML; i++) begin
                m_x[i] = (i < 3) ? CW'(32 - i) : '0;
                m_y[i] = (i < 3) ? CW'(24) : '0;
            end
            m_len = 3; m_dir = 2'd1; m_gp = 0; m_cnt = 0;
            m_done = 0; m_ovr = 0; m_valid = 1;
        end else if (respawn_valid) begin
            m_x[0] = respawn_x;
            m_y[0] = respawn_y;
            m_len  = (respawn_length == '0) ? 1 : int'(respawn_length);
            m_cnt = 0; m_done = 0; m_gp = 0;
        end else begin
            m_done = 0;
            if (m_cnt > 0) begin
                if (move_tick) m_ovr = 1;
                m_cnt--;
                if (m_cnt == 0) begin
                    for (int i = 0; i <= ML; i++) begin
                        m_x[i] = p_x[i];
                        m_y[i] = p_y[i];
                    end
                    m_len  = p_len;
                    m_done = 1;
                    m_gp   = grow | (m_gp & !m_step_grow);
                end else begin
                    m_gp = m_gp | grow;
                end
            end else begin
                if (move_tick) begin
                    if (!(m_len > 1 && is_reversal(m_dir, dir_in))) m_dir = dir_in;
                    m_g = m_gp | grow;
                    m_step_grow = m_g;
                    p_len = (m_g && m_len < ML) ? m_len + 1 : m_len;
                    for (int i = 0; i <= ML; i++) begin
                        p_x[i] = m_x[i];
                        p_y[i] = m_y[i];
                    end
                    for (int i = 1; i < p_len; i++) begin
                        p_x[i] = m_x[i-1];
                        p_y[i] = m_y[i-1];
                    end
                    case (m_dir)
                        2'd0: p_y[0] = m_y[0] - 10'd1;
                        2'd1: p_x[0] = m_x[0] + 10'd1;
                        2'd2: p_y[0] = m_y[0] + 10'd1;
                        default: p_x[0] = m_x[0] - 10'd1;
                    endcase
                    m_cnt = p_len;
                end
                m_gp = m_gp | grow;
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy", int'(busy), int'(m_cnt > 0));
            chk("step_done", int'(step_done), int'(m_done));
            chk("overrun", int'(overrun), int'(m_ovr));
            chk("length", int'(snake_length), m_len);
            chk("head_x", int'(head_x), int'(m_x[0]));
            chk("head_y", int'(head_y), int'(m_y[0]));
            if (m_cnt == 0 && int'(body_rd_addr) < m_len) begin
                chk("rd_x", int'(body_rd_x), int'(m_x[body_rd_addr]));
                chk("rd_y", int'(body_rd_y), int'(m_y[body_rd_addr]));
            end
        end
    end

    // Read-address sweep over the live body.
    initial begin
        body_rd_addr = '0;
        forever begin
            @(posedge clk); #1;
            if (!addr_hold)
                body_rd_addr = (int'(body_rd_addr) + 1 >= m_len) ? '0 : body_rd_addr + 6'd1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic rd_chk(input string nm, input int a, input int ex, input int ey);
        @(negedge clk); #2;
        addr_hold = 1;
        body_rd_addr = LW'(a);
        #1;
        chk({nm, "_x"}, int'(body_rd_x), ex);
        chk({nm, "_y"}, int'(body_rd_y), ey);
        addr_hold = 0;
    endtask

    task automatic clear_inputs();
        move_tick = 0; grow = 0; respawn_valid = 0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; clear_inputs(); end
    endtask

    task automatic do_reset();
        @(posedge clk); #1; clear_inputs(); reset = 0;
        @(posedge clk); #1; reset = 1;
    endtask

    task automatic pulse_tick(input logic [1:0] d);
        @(posedge clk); #1; clear_inputs(); move_tick = 1; dir_in = d;
        @(posedge clk); #1; move_tick = 0;
    endtask

    task automatic do_respawn(input int x, input int y, input int len);
        @(posedge clk); #1; clear_inputs();
        respawn_valid = 1; respawn_x = CW'(x); respawn_y = CW'(y); respawn_length = LW'(len);
        @(posedge clk); #1; respawn_valid = 0;
    endtask

    // Returns cycles from the tick edge to the step_done pulse, or -1.
    task automatic wait_done(input int limit, output int lat);
        lat = 0;
        while (lat < limit) begin
            @(negedge clk);
            if (step_done) return;
            lat++;
        end
        n_checks++;
        $display("FAIL step_done_timeout: none within %0d cycles, required a pulse", limit);
        lat = -1;
    endtask

    int lat;
    int seen;

    initial begin
        reset = 0; dir_in = 2'd0; respawn_x = '0; respawn_y = '0; respawn_length = '0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 reset = 1;

        // Reset state
        @(negedge clk);
        chk("rst_head_x", int'(head_x), 32);
        chk("rst_head_y", int'(head_y), 24);
        chk("rst_len", int'(snake_length), 3);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(overrun), 0);
        rd_chk("rst_body2", 2, 30, 24);

        // One step right: busy three cycles, then a single step_done
        pulse_tick(2'b01);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t1_busy", int'(busy), 1);
        end
        @(negedge clk);
        chk("t1_done", int'(step_done), 1);
        chk("t1_busy_end", int'(busy), 0);
        chk("t1_head_x", int'(head_x), 33);
        chk("t1_head_y", int'(head_y), 24);
        chk("t1_len", int'(snake_length), 3);
        chk("t1_model_head_x", int'(m_x[0]), 33);
        @(negedge clk);
        chk("t1_done_once", int'(step_done), 0);
        rd_chk("t1_body1", 1, 32, 24);
        rd_chk("t1_body2", 2, 31, 24);

        // Grow then step down
        do_reset();
        @(posedge clk); #1; grow = 1;
        pulse_tick(2'b10);
        wait_done(20, lat);
        chk("t2_latency", lat, 4);
        chk("t2_len", int'(snake_length), 4);
        chk("t2_head_x", int'(head_x), 32);
        chk("t2_head_y", int'(head_y), 25);
        chk("t2_model_len", m_len, 4);
        rd_chk("t2_body3", 3, 30, 24);
        rd_chk("t2_body1", 1, 32, 24);

        // Reset mid-step, then a reversal attempt while moving right
        pulse_tick(2'b10);
        @(posedge clk); #1; reset = 0;
        @(posedge clk); #1; reset = 1;
        @(negedge clk);
        chk("t3_rst_busy", int'(busy), 0);
        chk("t3_rst_head_y", int'(head_y), 24);
        pulse_tick(2'b11);
        wait_done(20, lat);
        chk("t3_latency", lat, 3);
        chk("t3_head_x", int'(head_x), 33);
        chk("t3_head_y", int'(head_y), 24);

        // Second tick while busy: dropped, overrun sticks
        pulse_tick(2'b01);
        move_tick = 1; dir_in = 2'b10;
        @(posedge clk); #1; move_tick = 0;
        wait_done(20, lat);
        chk("t4_overrun", int'(overrun), 1);
        chk("t4_head_x", int'(head_x), 34);
        chk("t4_head_y", int'(head_y), 24);
        idle_cycles(6);
        @(negedge clk);
        chk("t4_overrun_sticky", int'(overrun), 1);
        chk("t4_one_step", int'(head_x), 34);

        // Respawn mid-shift with length 0
        pulse_tick(2'b01);
        respawn_valid = 1; respawn_x = 10'd10; respawn_y = 10'd12; respawn_length = '0;
        @(posedge clk); #1; respawn_valid = 0;
        @(negedge clk);
        chk("t5_busy", int'(busy), 0);
        chk("t5_head_x", int'(head_x), 10);
        chk("t5_head_y", int'(head_y), 12);
        chk("t5_len", int'(snake_length), 1);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (step_done) seen++;
        end
        chk("t5_no_done", seen, 0);
        pulse_tick(2'b00);
        wait_done(10, lat);
        chk("t5_latency", lat, 1);
        chk("t5_up_x", int'(head_x), 10);
        chk("t5_up_y", int'(head_y), 11);

        // Underflow of x at the left edge
        do_respawn(0, 5, 1);
        pulse_tick(2'b11);
        wait_done(10, lat);
        chk("t6_head_x", int'(head_x), 1023);
        chk("t6_head_y", int'(head_y), 5);

        // Respawn and tick together: tick dropped, no overrun
        do_reset();
        @(posedge clk); #1;
        respawn_valid = 1; move_tick = 1; dir_in = 2'b01;
        respawn_x = 10'd40; respawn_y = 10'd40; respawn_length = 6'd2;
        @(posedge clk); #1; clear_inputs();
        @(negedge clk);
        chk("t7_busy", int'(busy), 0);
        chk("t7_overrun", int'(overrun), 0);
        chk("t7_len", int'(snake_length), 2);
        chk("t7_head_x", int'(head_x), 40);
        idle_cycles(3);

        // Growth saturates at MAX_LENGTH
        do_respawn(100, 100, 63);
        @(posedge clk); #1; grow = 1;
        pulse_tick(2'b01);
        wait_done(100, lat);
        chk("t8_latency", lat, 63);
        chk("t8_len", int'(snake_length), 63);
        chk("t8_head_x", int'(head_x), 101);
        chk("t8_head_y", int'(head_y), 100);
        rd_chk("t8_body1", 1, 100, 100);
        idle_cycles(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

endmodule

// File: doc/snake_body_engine.md
# snake_body_engine

Snake movement engine: owns the head/body coordinate store, advances the snake one block per `move_tick` in the latched direction, and grows on request. It also accepts respawn commands from the collision/fruit block. It is the producer side of the collision block's interface: it generates the head coordinates, body coordinates and length that the collision block consumes, and applies the new head/length that block returns. The body is exposed through a random-access read port so the collision checker can scan it between steps.

## Interface
Parameters:
- `COORD_WIDTH`, 10, coordinate width in bits
- `MAX_LENGTH`, 63, highest body index; the store holds `MAX_LENGTH`+1 entries
- `LENGTH_WIDTH`, 6, width of length values
- `START_X`, 32, reset head x
- `START_Y`, 24, reset head y
- `START_LEN`, 3, reset length (1..`MAX_LENGTH`)

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `reset` in 1: synchronous, active-low
- `move_tick` in 1: single-cycle step request
- `dir_in` in 2: 00 up (y-1), 01 right (x+1), 10 down (y+1), 11 left (x-1)
- `grow` in 1: pulse requesting +1 length on the next step
- `respawn_valid` in 1: apply respawn this cycle
- `respawn_x`, `respawn_y` in `COORD_WIDTH`: respawn head position
- `respawn_length` in `LENGTH_WIDTH`: respawn length
- `body_rd_addr` in `LENGTH_WIDTH`: read index (0 = head)
- `body_rd_x`, `body_rd_y` out `COORD_WIDTH`: combinational read of the entry at `body_rd_addr`
- `head_x`, `head_y` out `COORD_WIDTH`: entry 0, registered
- `snake_length` out `LENGTH_WIDTH`: current length
- `busy` out 1: step in progress
- `step_done` out 1: one-cycle pulse when a step completes
- `overrun` out 1: sticky; a `move_tick` arrived while `busy`

## Operation
- States:
  - IDLE: wait for a step request.
  - SHIFT: serial body shift, one entry per cycle, from the top index down to 1.
  - HEAD: update entry 0 and complete the step.
- IDLE → SHIFT: on `move_tick`. Latch `dir_in` into `cur_dir`, except an exact reversal (up↔down, left↔right) while `snake_length`>1; a reversal is ignored and `cur_dir` is kept. Latch `grow_pend`. Set the shift index to `snake_length`-1, or to `snake_length` if growing and `snake_length`<`MAX_LENGTH`.
- SHIFT: `entry[idx] <= entry[idx-1]`, then decrement `idx`. Go to HEAD once entry 1 is written. With a shift count of 0, go directly to HEAD.
- HEAD: entry 0 moves one unit in `cur_dir`. Arithmetic is modulo 2^`COORD_WIDTH` with no wrap to the display; 0-1 becomes 1023, and the collision block flags it. Apply the length increment if growing, pulse `step_done`, return to IDLE.
- `grow` is sampled in any state into `grow_pend`, which is cleared when consumed in HEAD. At `snake_length`==`MAX_LENGTH`, growth saturates and is silently dropped.
- `move_tick` while `busy`: ignored, sets `overrun`. Only `reset` clears `overrun`.
- `respawn_valid` has top priority in any state:
  - entry 0 ← (`respawn_x`, `respawn_y`)
  - `snake_length` ← `respawn_length`, clamped to 1..`MAX_LENGTH` (0 becomes 1)
  - any in-progress step is aborted; state goes to IDLE, `grow_pend` and `step_done` clear, `cur_dir` is unchanged
  - entries ≥ new length are don't-care
- If `respawn_valid` and `move_tick` arrive in the same cycle, the respawn wins and the tick is dropped without setting `overrun`.
- Read port: combinational. Its contents are defined only while `busy`=0. Addresses ≥ `snake_length` return stale data.

## Timing
- Reset (`reset`=0 at an edge):
  - `snake_length`=`START_LEN`
  - entry i = (`START_X`-i, `START_Y`) for i<`START_LEN`; other entries 0
  - `cur_dir`=right
  - `busy`=0, `step_done`=0, `overrun`=0, `grow_pend`=0, state IDLE
  - a reset asserted mid-step overrides everything
- Let N = shift count (L-1, or L when growing), where the tick is sampled at edge 0:
  - `busy`=1 after edge 0
  - SHIFT occupies edges 1..N
  - HEAD is edge N+1; after it, `head_x`/`head_y` and `snake_length` hold the new values, `step_done`=1 and `busy`=0 for exactly one cycle
- Step latency is N+1 cycles. For L=1 with no growth, `step_done` follows 1 cycle after the tick edge.
- A `move_tick` in the same cycle that `step_done` is high is accepted, since the state is IDLE.
- Respawn takes effect at the edge that samples it. `busy`=0 after that edge.

## Test plan
- Reset, then one tick with `dir_in`=01: `busy` high for 3 cycles; after them head=(33,24), body[1]=(32,24), body[2]=(31,24); `step_done` pulses once; length stays 3.
- From reset, `grow` pulse then tick with `dir_in`=10: length 4, head=(32,25), body[3]=(30,24); `step_done` 4 cycles after the tick edge.
- Moving right with length 3, tick with `dir_in`=11: the reversal is ignored, head x increments to 33.
- Tick, then a second tick 1 cycle later while busy: the second tick is dropped, `overrun`=1 and stays set, only one step occurs.
- Respawn mid-shift with (10,12) and length 0: head=(10,12), length=1, `busy`=0, `step_done` never pulses; next tick `dir_in`=00 gives head=(10,11).
- Respawn at (0,5) with length 1, tick `dir_in`=11: `head_x`=1023, `head_y`=5.
